// File: rtl/coeff_stream_loader.sv
// Pairs host re/im beats into {re,im} coefficient writes for the Expand stage, with spaced write strobes.
// Optional range checking of beat sign extension is enabled with COEFF_LOADER_RANGE_CHECK_EN.
`ifndef OVERALL_BITS
`define OVERALL_BITS 27
`endif

module coeff_stream_loader #(
  parameter int LOGN     = 13,
  parameter int IN_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         expand_mode,
  output logic                         busy,
  output logic                         done,
  input  logic [IN_WIDTH-1:0]          s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [LOGN-1:0]              addr_to_expand,
  output logic [2*`OVERALL_BITS-1:0]   data_to_expand,
  output logic                         wea_to_expand,
  output logic                         do_expand,
  output logic                         expand_rst,
  output logic                         err
);

  localparam int OB = `OVERALL_BITS;
  localparam logic [LOGN:0] TGT_DIRECT = {1'b1, {LOGN{1'b0}}};
  localparam logic [LOGN:0] TGT_EXPAND = {2'b01, {(LOGN-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RECV_RE = 3'd2,
    ST_RECV_IM = 3'd3,
    ST_WRITE   = 3'd4,
    ST_GAP     = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [LOGN:0]   cnt_r, cnt_nxt_s, cnt_inc_s, target_s;
  logic            mode_r, mode_nxt_s;
  logic            start_acc_s, beat_s;
  logic [OB-1:0]   re_r, im_r;
  logic [LOGN-1:0] addr_r;
  logic            busy_r, done_r, wea_r, do_expand_r, expand_rst_r;

  assign start_acc_s = start && (state_r == ST_IDLE);
  assign s_ready     = (state_r == ST_RECV_RE) || (state_r == ST_RECV_IM);
  assign beat_s      = s_valid && s_ready;
  assign cnt_inc_s   = cnt_r + {{LOGN{1'b0}}, 1'b1};
  assign target_s    = mode_r ? TGT_EXPAND : TGT_DIRECT;

  // Next-state, coefficient count and mode selection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mode_nxt_s  = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = expand_mode ? ST_CLEAR : ST_RECV_RE;
          mode_nxt_s  = expand_mode;
          cnt_nxt_s   = {(LOGN+1){1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR:   state_nxt_s = ST_RECV_RE;
      ST_RECV_RE: begin
        if (s_valid) begin
          state_nxt_s = ST_RECV_IM;
        end else begin
          state_nxt_s = ST_RECV_RE;
        end
      end
      ST_RECV_IM: begin
        if (s_valid) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_RECV_IM;
        end
      end
      ST_WRITE:   state_nxt_s = ST_GAP;
      ST_GAP: begin
        cnt_nxt_s = cnt_inc_s;
        // Count compared after this coefficient is included, so the last GAP ends the load.
        if (cnt_inc_s < target_s) begin
          state_nxt_s = ST_RECV_RE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DONE:    state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counter and captured mode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {(LOGN+1){1'b0}};
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      mode_r  <= mode_nxt_s;
    end
  end

  // Control outputs registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      wea_r        <= 1'b0;
      do_expand_r  <= 1'b0;
      expand_rst_r <= 1'b0;
      addr_r       <= {LOGN{1'b0}};
    end else begin
      busy_r       <= (state_nxt_s != ST_IDLE);
      done_r       <= (state_nxt_s == ST_DONE);
      wea_r        <= (state_nxt_s == ST_WRITE);
      do_expand_r  <= (state_nxt_s != ST_IDLE) && mode_nxt_s;
      expand_rst_r <= (state_nxt_s == ST_CLEAR);
      if (state_nxt_s == ST_WRITE) begin
        addr_r <= mode_r ? {LOGN{1'b0}} : cnt_r[LOGN-1:0];
      end else if (start_acc_s) begin
        addr_r <= {LOGN{1'b0}};
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  // Coefficient halves captured on their handshakes; held until the next re is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_r <= {OB{1'b0}};
      im_r <= {OB{1'b0}};
    end else begin
      if (beat_s && (state_r == ST_RECV_RE)) begin
        re_r <= s_data[OB-1:0];
      end else begin
        re_r <= re_r;
      end
      if (beat_s && (state_r == ST_RECV_IM)) begin
        im_r <= s_data[OB-1:0];
      end else begin
        im_r <= im_r;
      end
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign wea_to_expand  = wea_r;
  assign do_expand      = do_expand_r;
  assign expand_rst     = expand_rst_r;
  assign addr_to_expand = addr_r;
  assign data_to_expand = {re_r, im_r};

`ifdef COEFF_LOADER_RANGE_CHECK_EN
  // A beat is in range when everything from the half's sign bit upward is a pure sign extension.
  function automatic logic is_sign_ext(input logic [IN_WIDTH-1:0] d);
    logic [IN_WIDTH-OB:0] top_s;
    top_s = d[IN_WIDTH-1:OB-1];
    return (&top_s) | ~(|top_s);
  endfunction

  logic err_r;

  // Sticky range error, cleared by a newly accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (start_acc_s) begin
      err_r <= 1'b0;
    end else if (beat_s && !is_sign_ext(s_data)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;

  if (IN_WIDTH > OB) begin : g_upper
    logic unused_upper_s;
    assign unused_upper_s = ^s_data[IN_WIDTH-1:OB];
  end
`endif

endmodule

// File: tb/tb_coeff_stream_loader.sv
// Scoreboard bench for coeff_stream_loader: drivers push expected writes, a monitor checks each strobe.
`ifndef OVERALL_BITS
`define OVERALL_BITS 27
`endif

module tb_coeff_stream_loader;
  localparam int LOGN = 3;
  localparam int IW   = 32;
  localparam int OB   = `OVERALL_BITS;
  localparam int DW   = 2 * OB;

  logic            clk, rst, start, expand_mode, s_valid;
  logic [IW-1:0]   s_data;
  logic            busy, done, s_ready, wea_to_expand, do_expand, expand_rst, err;
  logic [LOGN-1:0] addr_to_expand;
  logic [DW-1:0]   data_to_expand;

  coeff_stream_loader #(.LOGN(LOGN), .IN_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .expand_mode(expand_mode),
    .busy(busy), .done(done), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .addr_to_expand(addr_to_expand), .data_to_expand(data_to_expand),
    .wea_to_expand(wea_to_expand), .do_expand(do_expand), .expand_rst(expand_rst), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [LOGN-1:0] addr;
    logic [DW-1:0]   data;
    logic            mode;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0, n_err = 0;
  int          strobes, erst_cnt, lat, done_lat, low_run;
  bit          seen_wea, err_m;
  logic [31:0] re_v[8], im_v[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic bit beat_bad(input logic [31:0] d);
    logic [31:0] top;
    top = d >> (OB - 1);
    return (top != 32'd0) && (top != ((32'd1 << (IW - OB + 1)) - 32'd1));
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_wea"}, wea_to_expand, 0);
    check({tag, "_do_expand"}, do_expand, 0);
    check({tag, "_expand_rst"}, expand_rst, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_addr"}, addr_to_expand, 0);
    check({tag, "_data"}, data_to_expand, 0);
  endtask

  // Monitor: pops the scoreboard on each strobe and tracks spacing, latency and reset pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wea_to_expand) begin
          strobes++;
          if (seen_wea) check("strobe_gap", low_run, (low_run >= 3) ? low_run : 3);
          seen_wea = 1'b1;
          low_run  = 0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_strobe: got addr %0d with empty scoreboard", addr_to_expand);
          end else begin
            mon_e = exp_q.pop_front();
            check("addr", addr_to_expand, mon_e.addr);
            check("data", data_to_expand, mon_e.data);
            check("do_expand", do_expand, mon_e.mode);
          end
        end else begin
          low_run++;
        end
        if (expand_rst) erst_cnt++;
        if (busy) lat++;
        if (done) done_lat = lat;
      end
    end
  end

  task automatic do_start(input logic mode);
    @(posedge clk); #1;
    start = 1'b1; expand_mode = mode;
    strobes = 0; erst_cnt = 0; lat = 0; done_lat = -1; seen_wea = 1'b0; low_run = 0; err_m = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; expand_mode = 1'b0;
    check("busy_rise", busy, 1);
    check("do_expand_start", do_expand, mode);
    check("expand_rst_start", expand_rst, mode);
    check("err_cleared", err, 0);
  endtask

  task automatic send_beat(input logic [31:0] d, input bit gaps);
    bit ok;
    ok = 1'b0;
    if (gaps) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 1) == 0) break;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1; s_data = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    s_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL beat_timeout: got no handshake in 100 cycles for data 0x%0h", d);
    end else begin
`ifdef COEFF_LOADER_RANGE_CHECK_EN
      if (beat_bad(d)) err_m = 1'b1;
`endif
      check("err_after_beat", err, err_m);
    end
  endtask

  task automatic run_load(input logic mode, input int n, input bit gaps,
                          input int mid_start_at, input int rst_at, input int exp_lat);
    exp_t e;
    bit   seen;
    do_start(mode);
    for (int k = 0; k < n; k++) begin
      if (k == mid_start_at) begin
        start = 1'b1; expand_mode = ~mode;
        @(posedge clk); #1;
        start = 1'b0; expand_mode = 1'b0;
      end
      e.addr = mode ? '0 : k[LOGN-1:0];
      e.data = {re_v[k][OB-1:0], im_v[k][OB-1:0]};
      e.mode = mode;
      exp_q.push_back(e);
      send_beat(re_v[k], gaps);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      send_beat(im_v[k], gaps);
    end
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    if (exp_lat >= 0) check("done_latency", done_lat, exp_lat);
    check("strobe_count", strobes, n);
    check("scoreboard_empty", exp_q.size(), 0);
    check("expand_rst_count", erst_cnt, mode);
    @(negedge clk);
    check("busy_fall", busy, 0);
    check("done_pulse", done, 0);
    check("do_expand_idle", do_expand, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 ns");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; expand_mode = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Direct, continuous beats: start..done spans 34 cycles inclusive, i.e. done on busy cycle 33.
    for (int k = 0; k < 8; k++) begin re_v[k] = k; im_v[k] = 100 + k; end
    run_load(1'b0, 8, 1'b0, -1, -1, 33);

    // Expand: CLEAR + 4 coefficients + DONE = 18 busy cycles.
    for (int k = 0; k < 8; k++) begin re_v[k] = 200 + k; im_v[k] = 32'hFFFF_FFF0 - k; end
    run_load(1'b1, 4, 1'b0, -1, -1, 18);

    // Random s_valid gaps.
    for (int k = 0; k < 8; k++) begin re_v[k] = 3 * k + 7; im_v[k] = 32'h0000_1000 + k; end
    run_load(1'b0, 8, 1'b1, -1, -1, -1);

    // Start pulsed mid-load with the opposite mode.
    for (int k = 0; k < 8; k++) begin re_v[k] = k; im_v[k] = 100 + k; end
    run_load(1'b0, 8, 1'b0, 3, -1, -1);

    // Reset after re of coefficient 2, then a clean reload from address 0.
    for (int k = 0; k < 8; k++) begin re_v[k] = 50 + k; im_v[k] = 60 + k; end
    run_load(1'b0, 8, 1'b0, -1, 2, -1);
    for (int k = 0; k < 8; k++) begin re_v[k] = k; im_v[k] = 100 + k; end
    run_load(1'b0, 8, 1'b0, -1, -1, 33);

    // Sign-extended beat, then an out-of-range beat; upper bits never reach the data.
    for (int k = 0; k < 8; k++) begin re_v[k] = k; im_v[k] = 100 + k; end
    re_v[0] = 32'hFC00_0001;
    re_v[1] = 32'h0800_0000;
    run_load(1'b0, 8, 1'b0, -1, -1, 33);
`ifdef COEFF_LOADER_RANGE_CHECK_EN
    check("err_sticky_after_load", err, 1);
`else
    check("err_tied_low", err, 0);
`endif

    // Next start clears the sticky error.
    for (int k = 0; k < 8; k++) begin re_v[k] = 8 - k; im_v[k] = 20 * k; end
    run_load(1'b1, 4, 1'b1, -1, -1, -1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
